// File: rtl/contador_rega.sv
`default_nettype none
// ============================================================================
//  Module   : contador_rega
//  Purpose  : Irrigation-cycle timer driving the valve and one BCD digit of
//             remaining time, plus an error flag for the display decoder.
//  Revision : 1.0  initial release
// ============================================================================
module contador_rega #(
  parameter int CLK_DIV = 50000000,
  parameter int DURACAO = 9
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  input  logic STOP,
  input  logic NIVEL_OK,
  input  logic UMIDO,
  input  logic CLR_ERR,
  output logic C3,
  output logic C2,
  output logic C1,
  output logic C0,
  output logic Er,
  output logic VALVULA,
  output logic FIM
);

  localparam int            PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [3:0]    DUR        = 4'(DURACAO);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REGANDO = 2'd1,
    ERRO    = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    count_q;
  logic [PW-1:0] presc_q;
  logic          er_q;
  logic          valv_q;
  logic          fim_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      presc_q <= '0;
      er_q    <= 1'b0;
      valv_q  <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      fim_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= 4'd0;
          presc_q <= '0;
          er_q    <= 1'b0;
          valv_q  <= 1'b0;
          if (START) begin
            if (!NIVEL_OK) begin
              state_q <= ERRO;
              er_q    <= 1'b1;
            end else if (!UMIDO) begin
              state_q <= REGANDO;
              count_q <= DUR;
              valv_q  <= 1'b1;
            end
          end
        end

        // Dry tank outranks manual abort so the operator always sees the fault.
        REGANDO: begin
          if (!NIVEL_OK) begin
            state_q <= ERRO;
            er_q    <= 1'b1;
            valv_q  <= 1'b0;
            presc_q <= '0;
          end else if (STOP || UMIDO) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            valv_q  <= 1'b0;
            presc_q <= '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            if (count_q > 4'd1) begin
              count_q <= count_q - 4'd1;
            end else begin
              state_q <= IDLE;
              count_q <= 4'd0;
              valv_q  <= 1'b0;
              fim_q   <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PRESC_ONE;
          end
        end

        ERRO: begin
          er_q    <= 1'b1;
          valv_q  <= 1'b0;
          presc_q <= '0;
          if (CLR_ERR) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            er_q    <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          count_q <= 4'd0;
          presc_q <= '0;
          er_q    <= 1'b0;
          valv_q  <= 1'b0;
        end
      endcase
    end
  end

  assign C3      = count_q[3];
  assign C2      = count_q[2];
  assign C1      = count_q[1];
  assign C0      = count_q[0];
  assign Er      = er_q;
  assign VALVULA = valv_q;
  assign FIM     = fim_q;

endmodule
`default_nettype wire
